// File: rtl/muldiv_seq_if.sv
// Handshake bundle between the EX stage and the iterative multiply/divide sequencer.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            ready;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, a, b, flush,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, funct3, a, b, flush,
    output ready, busy, done, result
  );
endinterface

// File: rtl/muldiv_seq.sv
// RV32M iterative sequencer: shift-add multiply / restoring divide, one bit per cycle.
// Latency XLEN+2 cycles to done (1 for div-by-zero/overflow); start ignored while busy; flush aborts.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [2:0]        op;
  logic              neg;
  logic              ready_r, busy_r, done_r;
  logic [XLEN-1:0]   result_r;

  logic              a_sgn, b_sgn, sa, sb, is_div, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag, fast_val;
  logic [XLEN:0]     mul_sum, div_tmp;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (bus.funct3)
      3'b001, 3'b100, 3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'b010:                 a_sgn = 1'b1;
      default:                ;
    endcase
  end

  assign sa       = a_sgn & bus.a[XLEN-1];
  assign sb       = b_sgn & bus.b[XLEN-1];
  assign a_mag    = sa ? -bus.a : bus.a;
  assign b_mag    = sb ? -bus.b : bus.b;
  assign is_div   = bus.funct3[2];
  assign div_zero = (bus.b == '0);
  assign div_ovf  = !bus.funct3[0] && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
  // Overflow quotient equals the dividend itself, so a doubles as both fast answers.
  assign fast_val = bus.funct3[1] ? (div_zero ? bus.a : '0) : (div_zero ? '1 : bus.a);

  // Multiply step: add multiplicand into the upper half, then shift the whole product right.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
  assign mul_next = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};

  // Divide step: acc holds {remainder, quotient}; the partial remainder never exceeds XLEN bits.
  assign div_tmp  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_ge   = (div_tmp >= {1'b0, opnd});
  assign div_diff = div_tmp[XLEN-1:0] - opnd;
  assign div_next = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1}
                           : {div_tmp[XLEN-1:0], acc[XLEN-2:0], 1'b0};

  assign prod_fix = neg ? -acc : acc;
  assign quot_fix = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_val = prod_fix[XLEN-1:0];
    case (op)
      3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_val = quot_fix;
      3'b110, 3'b111:         fix_val = rem_fix;
      default:                ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      op       <= '0;
      neg      <= 1'b0;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            op      <= bus.funct3;
            neg     <= (is_div && bus.funct3[1]) ? sa : (sa ^ sb);
            cnt     <= '0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            if (is_div && (div_zero || div_ovf)) begin
              result_r <= fast_val;
              done_r   <= 1'b1;
              state    <= DONE;
            end else begin
              acc   <= is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
              opnd  <= is_div ? b_mag : a_mag;
              state <= CALC;
            end
          end
        end
        default: begin
          if (bus.flush) begin
            state   <= IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            case (state)
              CALC: begin
                acc <= op[2] ? div_next : mul_next;
                cnt <= cnt + 1'b1;
                if (cnt == CW'(XLEN-1)) state <= FIX;
              end
              FIX: begin
                result_r <= fix_val;
                done_r   <= 1'b1;
                state    <= DONE;
              end
              default: begin
                state   <= IDLE;
                ready_r <= 1'b1;
                busy_r  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign bus.ready  = ready_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r & ~bus.flush;
  assign bus.result = result_r;
endmodule
